// File: rtl/host_intf_arbiter_pkg.sv
// Shared definitions for the two-requester host interface arbiter:
// FSM encoding, timeout default and the latched access-control bundle.
package host_intf_arbiter_pkg;

   localparam logic [1:0] StIdle    = 2'd0;
   localparam logic [1:0] StIssue   = 2'd1;
   localparam logic [1:0] StWait    = 2'd2;
   localparam logic [1:0] StRelease = 2'd3;

   localparam int unsigned TmoCycDefault = 1023;

   typedef struct packed {
      logic rd;
      logic wr;
      logic dftm;
   } ctl_t;

   // A request with both strobes up is served as a read.
   function automatic ctl_t mk_ctl(input logic rd, input logic wr, input logic dftm);
      ctl_t c;
      c.rd   = rd;
      c.wr   = wr & ~rd;
      c.dftm = dftm;
      return c;
   endfunction

endpackage

// File: rtl/host_intf_arbiter_if.sv
// Bundle of requester-side and downstream-side signals of the arbiter.
// The slave modport is the arbiter's view; master is the surrounding system's.
interface host_intf_arbiter_if #(
   parameter int unsigned ADDR_W = 24,
   parameter int unsigned DATA_W = 16
);
   logic              m0_rd_i;
   logic              m0_wr_i;
   logic              m0_dftm_i;
   logic [ADDR_W-1:0] m0_addr_i;
   logic [DATA_W-1:0] m0_data_i;
   logic [DATA_W-1:0] m0_data_o;
   logic              m0_done_o;
   logic              m0_err_o;

   logic              m1_rd_i;
   logic              m1_wr_i;
   logic              m1_dftm_i;
   logic [ADDR_W-1:0] m1_addr_i;
   logic [DATA_W-1:0] m1_data_i;
   logic [DATA_W-1:0] m1_data_o;
   logic              m1_done_o;
   logic              m1_err_o;

   logic              s_rd_o;
   logic              s_wr_o;
   logic              s_dftm_o;
   logic [ADDR_W-1:0] s_addr_o;
   logic [DATA_W-1:0] s_data_o;
   logic [DATA_W-1:0] s_data_i;
   logic              s_done_i;
   logic              s_rdPending_i;

   modport slave (
      input  m0_rd_i, m0_wr_i, m0_dftm_i, m0_addr_i, m0_data_i,
      output m0_data_o, m0_done_o, m0_err_o,
      input  m1_rd_i, m1_wr_i, m1_dftm_i, m1_addr_i, m1_data_i,
      output m1_data_o, m1_done_o, m1_err_o,
      output s_rd_o, s_wr_o, s_dftm_o, s_addr_o, s_data_o,
      input  s_data_i, s_done_i, s_rdPending_i
   );

   modport master (
      output m0_rd_i, m0_wr_i, m0_dftm_i, m0_addr_i, m0_data_i,
      input  m0_data_o, m0_done_o, m0_err_o,
      output m1_rd_i, m1_wr_i, m1_dftm_i, m1_addr_i, m1_data_i,
      input  m1_data_o, m1_done_o, m1_err_o,
      input  s_rd_o, s_wr_o, s_dftm_o, s_addr_o, s_data_o,
      output s_data_i, s_done_i, s_rdPending_i
   );

endinterface

// File: rtl/rr_arb2.sv
// Two-way round-robin selector: on contention the requester not granted
// last wins. last = 1 means requester 1 was granted most recently.
module rr_arb2 (
   input  logic [1:0] req,
   input  logic       last,
   output logic [1:0] gnt
);

   assign gnt[0] = req[0] & (~req[1] | last);
   assign gnt[1] = req[1] & (~req[0] | ~last);

endmodule

// File: rtl/host_intf_arbiter.sv
// Shares one downstream access port between two requesters with round-robin
// arbitration, a per-access timeout, and fully registered outputs.
module host_intf_arbiter
   import host_intf_arbiter_pkg::*;
#(
   parameter int unsigned ADDR_W  = 24,
   parameter int unsigned DATA_W  = 16,
   parameter int unsigned TMO_CYC = TmoCycDefault
) (
   input logic               clk_i,
   input logic               rst_n_i,
   host_intf_arbiter_if.slave bus
);

   localparam int unsigned TmoW = $clog2(TMO_CYC + 1);

   logic [1:0]        state_q, state_d;
   logic              last_q, last_d;
   logic              cur_q, cur_d;
   ctl_t              ctl_q, ctl_d;
   logic [ADDR_W-1:0] addr_q, addr_d;
   logic [DATA_W-1:0] wdata_q, wdata_d;
   logic [TmoW-1:0]   tmo_q, tmo_d;
   logic [DATA_W-1:0] m0_data_q, m0_data_d;
   logic [DATA_W-1:0] m1_data_q, m1_data_d;
   logic [1:0]        done_q, done_d;
   logic [1:0]        err_q, err_d;
   logic [1:0]        req;
   logic [1:0]        gnt;

   assign req = {bus.m1_rd_i | bus.m1_wr_i, bus.m0_rd_i | bus.m0_wr_i};

   rr_arb2 u_rr_arb2 (
      .req  (req),
      .last (last_q),
      .gnt  (gnt)
   );

   always_comb begin
      state_d   = state_q;
      last_d    = last_q;
      cur_d     = cur_q;
      ctl_d     = ctl_q;
      addr_d    = addr_q;
      wdata_d   = wdata_q;
      tmo_d     = tmo_q;
      m0_data_d = m0_data_q;
      m1_data_d = m1_data_q;
      done_d    = '0;
      err_d     = '0;
      case (state_q)
         StIdle: begin
            if (!bus.s_rdPending_i && (gnt != 2'b00)) begin
               cur_d   = gnt[1];
               last_d  = gnt[1];
               ctl_d   = gnt[1] ? mk_ctl(bus.m1_rd_i, bus.m1_wr_i, bus.m1_dftm_i)
                                : mk_ctl(bus.m0_rd_i, bus.m0_wr_i, bus.m0_dftm_i);
               addr_d  = gnt[1] ? bus.m1_addr_i : bus.m0_addr_i;
               wdata_d = gnt[1] ? bus.m1_data_i : bus.m0_data_i;
               tmo_d   = '0;
               state_d = StIssue;
            end
         end
         StIssue, StWait: begin
            if (bus.s_done_i) begin
               done_d[cur_q] = 1'b1;
               if (ctl_q.rd) begin
                  if (cur_q) m1_data_d = bus.s_data_i;
                  else       m0_data_d = bus.s_data_i;
               end
               ctl_d.rd = 1'b0;
               ctl_d.wr = 1'b0;
               state_d  = StRelease;
            end else if (state_q == StIssue) begin
               state_d = StWait;
            end else begin
               tmo_d = tmo_q + TmoW'(1);
               if (tmo_d == TmoW'(TMO_CYC)) begin
                  err_d[cur_q] = 1'b1;
                  ctl_d.rd     = 1'b0;
                  ctl_d.wr     = 1'b0;
                  state_d      = StRelease;
               end
            end
         end
         default: state_d = StIdle;
      endcase
   end

   always_ff @(posedge clk_i or negedge rst_n_i) begin
      if (!rst_n_i) begin
         state_q   <= StIdle;
         last_q    <= 1'b1;
         cur_q     <= 1'b0;
         ctl_q     <= '0;
         addr_q    <= '0;
         wdata_q   <= '0;
         tmo_q     <= '0;
         m0_data_q <= '0;
         m1_data_q <= '0;
         done_q    <= '0;
         err_q     <= '0;
      end else begin
         state_q   <= state_d;
         last_q    <= last_d;
         cur_q     <= cur_d;
         ctl_q     <= ctl_d;
         addr_q    <= addr_d;
         wdata_q   <= wdata_d;
         tmo_q     <= tmo_d;
         m0_data_q <= m0_data_d;
         m1_data_q <= m1_data_d;
         done_q    <= done_d;
         err_q     <= err_d;
      end
   end

   assign bus.s_rd_o    = ctl_q.rd;
   assign bus.s_wr_o    = ctl_q.wr;
   assign bus.s_dftm_o  = ctl_q.dftm;
   assign bus.s_addr_o  = addr_q;
   assign bus.s_data_o  = wdata_q;
   assign bus.m0_data_o = m0_data_q;
   assign bus.m1_data_o = m1_data_q;
   assign bus.m0_done_o = done_q[0];
   assign bus.m1_done_o = done_q[1];
   assign bus.m0_err_o  = err_q[0];
   assign bus.m1_err_o  = err_q[1];

endmodule

// File: doc/host_intf_arbiter.md
HOST_INTF_ARBITER -- requirements
Module: host_intf_arbiter

Interface
REQ-001 SHALL have parameters (name, default, meaning):
- ADDR_W, 24, address width
- DATA_W, 16, data width
- TMO_CYC, 1023, cycles allowed for downstream done before abort
REQ-002 SHALL have ports (name, direction, width, meaning):
- clk_i  in  1  sole clock; all logic on its rising edge
- rst_n_i  in  1  reset, asynchronous, active-low
- mN_rd_i  in  1  requester N (N=0,1) read request; level, held until mN_done_o
- mN_wr_i  in  1  requester N write request; level, held until mN_done_o
- mN_dftm_i  in  1  requester N fault-tolerance mode flag for this access
- mN_addr_i  in  ADDR_W  requester N address
- mN_data_i  in  DATA_W  requester N write data
- mN_data_o  out  DATA_W  requester N read data; valid with mN_done_o
- mN_done_o  out  1  requester N completion pulse, one cycle
- mN_err_o  out  1  requester N timeout pulse, one cycle
- s_rd_o  out  1  downstream read strobe
- s_wr_o  out  1  downstream write strobe
- s_dftm_o  out  1  downstream dftm flag
- s_addr_o  out  ADDR_W  downstream address
- s_data_o  out  DATA_W  downstream write data
- s_data_i  in  DATA_W  downstream read data
- s_done_i  in  1  downstream completion pulse
- s_rdPending_i  in  1  downstream read in flight

Function
REQ-003 SHALL implement FSM states IDLE, ISSUE, WAIT, RELEASE.
REQ-004 IDLE: a requester is active when rd_i|wr_i is high; if any is active, SHALL grant one, latch its rd, wr, dftm, addr and data, and go to ISSUE.
REQ-005 Arbitration SHALL be round-robin: when both are active, the one not granted last wins; after reset m0 has priority.
REQ-006 If rd_i and wr_i are both high on the granted requester, SHALL treat it as a read and ignore wr.
REQ-007 ISSUE and WAIT: SHALL drive s_rd_o/s_wr_o, s_dftm_o, s_addr_o and s_data_o from the latched values, held constant until s_done_i; ISSUE lasts exactly one cycle, then WAIT.
REQ-008 On s_done_i in ISSUE or WAIT:
- SHALL pulse the granted mN_done_o the next cycle.
- For reads, SHALL present s_data_i (registered on the done cycle) on mN_data_o in that same cycle.
- SHALL go to RELEASE.
REQ-009 RELEASE: SHALL deassert s_rd_o/s_wr_o for one cycle, then return to IDLE, which gives the requester a cycle to drop its request.
REQ-010 A requester still asserting rd/wr in IDLE after its done SHALL be treated as a new request.
REQ-011 A timeout counter SHALL clear on entry to ISSUE and increment each cycle in WAIT. If it reaches TMO_CYC without s_done_i, SHALL pulse mN_err_o (no done) and go to RELEASE.
REQ-012 A late s_done_i arriving in RELEASE or IDLE SHALL be ignored.
REQ-013 SHALL not grant while s_rdPending_i is high in IDLE; it stays in IDLE until s_rdPending_i drops.
REQ-014 The non-granted requester's mN_done_o and mN_err_o SHALL stay low, and its mN_data_o SHALL hold its last value.
REQ-015 Requests that drop before a grant SHALL be lost without error. Changes to mN_addr_i or mN_data_i after grant SHALL have no effect.

Reset
REQ-016 While rst_n_i is low:
- state = IDLE; last-grant pointer = m1, so m0 wins next.
- timeout counter = 0.
- all s_* outputs, mN_data_o, mN_done_o and mN_err_o = 0.
REQ-017 Reset mid-access SHALL abort the access immediately with no done or err pulse. Downstream re-sync is the system's responsibility.

Structure
REQ-018 The state encoding and the TMO_CYC default SHALL live in the shared dftm package.
REQ-019 Round-robin selection SHALL be one sub-module, rr_arb2 (inputs: two requests, last-grant; outputs: one-hot grant), combinational.
REQ-020 All outputs SHALL be driven from registers.

Verification
REQ-021 After reset, m0 reads 0x000010 and the model returns 0xBEEF with done 3 cycles later -> s_rd_o high for 4 cycles with s_addr_o=0x000010; m0_done_o pulses once with m0_data_o=0xBEEF.
REQ-022 m0 and m1 both request in the same cycle -> m0 served first, then m1. With both requesting continuously, grants alternate m0,m1,m0,m1.
REQ-023 m1 writes 0x1234 to 0xFFFFFF with dftm=1 -> s_wr_o, s_data_o=0x1234, s_addr_o=0xFFFFFF and s_dftm_o=1 are held stable until done; m0 outputs stay idle.
REQ-024 Model never returns done, TMO_CYC=15 -> m0_err_o pulses after 15 WAIT cycles. A done injected afterwards is ignored, and the next request completes normally.
REQ-025 rst_n_i asserted during WAIT -> all outputs are 0 asynchronously, with no done or err pulse. After release, m0 wins the first contention.
REQ-026 s_rdPending_i held high with a pending m0 request -> no grant until it drops; the grant follows on the next cycle.
